pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch stage of the MIPS core. Holds the architectural PC and presents it to the `npc` next-PC logic. Fetches the instruction at PC from instruction memory over a variable-latency req/ack port and holds it for decode under a valid/ready handshake. When decode accepts the instruction, the block loads the `npc` result as the new PC. A flush input redirects fetch and discards any in-flight response.

## Interface
Parameters:
- `RESET_PC`, default 30'h0000_0C00 (byte address 0x3000): word address loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `pc`  out  30  current PC[31:2]; drives `npc.PC`.
- `npc`  in  30  next PC[31:2] from `npc.NPC`, computed from `pc` and the held instruction.
- `imem_req`  out  1  fetch request; held high until acknowledged.
- `imem_addr`  out  30  word address of the request; stable while `imem_req` is high.
- `imem_ack`  in  1  one-cycle response strobe; sampled only while `imem_req` is high.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack` is high.
- `instr`  out  32  held instruction for decode.
- `instr_valid`  out  1  `instr` is valid for `pc`.
- `instr_ready`  in  1  decode accepts the instruction this cycle.
- `flush`  in  1  redirect request.
- `flush_pc`  in  30  redirect target.
- `fetch_cnt`  out  32  accepted-instruction counter (see Configuration).
- `stall_cnt`  out  32  memory-wait cycle counter (see Configuration).

## Operation
- The block has four states: IDLE, REQ, VALID and DROP.
  - `imem_req` is high exactly in REQ and DROP.
  - `instr_valid` is high exactly in VALID.
- The internal register `req_addr` drives `imem_addr`. It is distinct from `pc` so the address stays stable through DROP.
- IDLE (entered only from reset):
  - Next cycle: `req_addr`<=`pc`, go to REQ.
  - If `flush` is high in IDLE: `pc`<=`req_addr`<=`flush_pc`, then go to REQ.
- REQ:
  - On `imem_ack`: `instr`<=`imem_rdata`, go to VALID.
  - With no ack, stay in REQ.
- VALID:
  - On `instr_ready`: `pc`<=`npc`, `req_addr`<=`npc`, go to REQ.
  - Otherwise hold `pc` and `instr` unchanged.
- DROP:
  - Wait for `imem_ack` and discard `imem_rdata`.
  - On ack: `req_addr`<=`pc`, go to REQ.
- Flush takes priority over `instr_ready` and over `imem_ack` capture:
  - In VALID: the instruction is dropped. `pc`<=`req_addr`<=`flush_pc`, go to REQ.
  - In REQ without ack: `pc`<=`flush_pc`, go to DROP. `req_addr` keeps the old address.
  - In REQ with ack in the same cycle: the data is discarded. `pc`<=`req_addr`<=`flush_pc`, go to REQ.
  - In DROP without ack: `pc`<=`flush_pc`, stay in DROP. Only the latest flush target survives.
  - In DROP with ack: `pc`<=`req_addr`<=`flush_pc`, go to REQ.
- `npc` is consumed only on the VALID and `instr_ready` transfer. It is ignored in every other cycle.
- PC arithmetic is done by `npc`. The block performs no addition and allows 30-bit wrap freely.

## Timing
- Reset values: state IDLE, `pc`=`req_addr`=`RESET_PC`, `instr`=32'h0, `imem_req`=0, `instr_valid`=0, counters 0.
- `rst` high in any state returns the block to reset values on that edge. An outstanding memory response is not tracked across reset.
- The first `imem_req` is asserted on the cycle after `rst` deasserts.
- Fetch latency is ack latency plus one cycle. A zero-wait memory (ack in the cycle of request) gives `instr_valid` on the next cycle.
- Back-to-back throughput is one instruction per two cycles (REQ, VALID) with zero-wait memory.
- `imem_req` and `instr_valid` are decoded from registered state and have no combinational input-to-output paths. `imem_ack` arriving while `imem_req` is low is ignored.

## Configuration
- Macro `FETCH_PERF_CNT_EN`:
  - Defined:
    - `fetch_cnt` increments on each VALID and `instr_ready` transfer that is not flushed.
    - `stall_cnt` increments on each REQ or DROP cycle with `imem_ack` low.
    - Both counters wrap at 2^32 and reset to 0.
  - Undefined: both outputs are constant 0 and no counter flops are built.

## Test plan
- Reset release, zero-wait memory returning 32'h2408_0001 at 0xC00, `instr_ready`=1, `npc`=`pc`+1:
  - `imem_req` first appears 1 cycle after reset.
  - `pc` steps 0xC00, 0xC01, 0xC02 with `instr_valid` every other cycle.
- Ack delayed 3 cycles: `imem_addr` stays stable for 4 cycles, `instr_valid` rises 1 cycle after ack, and `stall_cnt`=3 per fetch (macro defined).
- Decode holds `instr_ready`=0 for 5 cycles in VALID: `pc`, `instr` and `instr_valid` stay unchanged, `npc` is ignored, and no request is issued.
- Flush to 0x1000 while an ack is 2 cycles away:
  - The block goes to DROP and the old response is discarded.
  - The next `imem_addr` is 0x1000 and no instruction from the old address is presented.
- Flush and `imem_ack` in the same REQ cycle: the data is discarded and the next cycle issues a request at `flush_pc`.
- Flush and `instr_ready` together in VALID: `fetch_cnt` is unchanged, `pc`=`flush_pc`, and `npc` is not loaded.

Source files
------------

// File: rtl/pc_fetch_if.sv
// pc_fetch_if
// Instruction-memory request/response port of the fetch stage.
//
// Signals:
//   imem_req    fetch request, held high until acknowledged
//   imem_addr   word address of the request, stable while imem_req is high
//   imem_ack    one-cycle response strobe, meaningful only while imem_req is high
//   imem_rdata  instruction word, valid when imem_ack is high
//
// Modports:
//   master  fetch side (drives req/addr, receives ack/rdata)
//   slave   memory side
interface pc_fetch_if;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch
// Instruction-fetch stage: holds the architectural PC, fetches the word at PC
// over a variable-latency req/ack memory port and presents it to decode.
// When decode accepts, the externally computed next PC (npc) becomes the PC.
// A flush redirects fetch and discards any response still in flight.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   defined   -> fetch_cnt / stall_cnt performance counters are built
//   undefined -> both counter outputs are constant 0
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   pc            current PC[31:2]
//   npc           next PC[31:2], consumed only on an accepted instruction
//   imem          instruction-memory port (pc_fetch_if.master)
//   instr         held instruction for decode
//   instr_valid   instr is valid for pc
//   instr_ready   decode accepts this cycle
//   flush         redirect request
//   flush_pc      redirect target
//   fetch_cnt     accepted-instruction counter
//   stall_cnt     memory-wait cycle counter
//   dbg_state     current FSM state (IDLE=0, REQ=1, VALID=2, DROP=3)
//
// Handshakes:
//   Memory: imem_req stays high with imem_addr stable until a cycle in which
//   imem_ack is high; that cycle completes the request. imem_ack while
//   imem_req is low is ignored.
//   Decode: a transfer happens on a cycle where instr_valid and instr_ready
//   are both high; instr_valid does not depend combinationally on
//   instr_ready, and instr is held stable while instr_valid waits.
module pc_fetch #(
    parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
    input  logic             clk,
    input  logic             rst,
    output logic [29:0]      pc,
    input  logic [29:0]      npc,
    pc_fetch_if.master       imem,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             flush,
    input  logic [29:0]      flush_pc,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      stall_cnt,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [29:0] pc_q, pc_d;
    // Address of the outstanding request; kept separate from pc so it stays
    // stable while an abandoned request drains in DROP.
    logic [29:0] req_addr_q, req_addr_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (flush) begin
                    pc_d       = flush_pc;
                    req_addr_d = flush_pc;
                end else begin
                    req_addr_d = pc_q;
                end
            end

            S_REQ: begin
                if (flush) begin
                    if (imem.imem_ack) begin
                        // Request completed this cycle: data discarded,
                        // redirect can be issued immediately.
                        pc_d       = flush_pc;
                        req_addr_d = flush_pc;
                        state_d    = S_REQ;
                    end else begin
                        // Request still outstanding: must drain it first.
                        pc_d    = flush_pc;
                        state_d = S_DROP;
                    end
                end else if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_VALID;
                end
            end

            S_VALID: begin
                if (flush) begin
                    pc_d       = flush_pc;
                    req_addr_d = flush_pc;
                    state_d    = S_REQ;
                end else if (instr_ready) begin
                    pc_d       = npc;
                    req_addr_d = npc;
                    state_d    = S_REQ;
                end
            end

            S_DROP: begin
                if (flush) begin
                    pc_d = flush_pc;
                    if (imem.imem_ack) begin
                        req_addr_d = flush_pc;
                        state_d    = S_REQ;
                    end
                end else if (imem.imem_ack) begin
                    // pc already holds the latest redirect target.
                    req_addr_d = pc_q;
                    state_d    = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        // A flushed acceptance is not a real fetch.
        if (state_q == S_VALID && instr_ready && !flush) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if ((state_q == S_REQ || state_q == S_DROP) && !imem.imem_ack) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign fetch_cnt = 32'd0;
    assign stall_cnt = 32'd0;
`endif

    assign pc             = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = (state_q == S_VALID);
    assign imem.imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
    assign imem.imem_addr = req_addr_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    logic        clk;
    logic        rst;
    logic [29:0] pc;
    logic [29:0] npc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic [29:0] flush_pc;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_fetch = 0;
    logic [31:0] exp_stall = 0;

    pc_fetch_if imem_bus ();

    pc_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .npc         (npc),
        .imem        (imem_bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Advance one rising edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; npc = '0; instr_ready = 1'b0; flush = 1'b0; flush_pc = '0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
        tick(); tick();
        checks++; if (pc !== 30'hC00) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 30'hC00); end
        checks++; if (imem_bus.imem_addr !== 30'hC00) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_bus.imem_addr, 30'hC00); end
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_bus.imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        checks++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", fetch_cnt, stall_cnt); end
        rst = 1'b0;
        tick();
        checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_bus.imem_req); end
        checks++; if (imem_bus.imem_addr !== 30'hC00) begin errors++; $display("FAIL first_addr: got %h want %h", imem_bus.imem_addr, 30'hC00); end
    endtask

    // Zero-wait memory, decode always ready, npc = pc + 1.
    task automatic test_zero_wait();
        logic [29:0] exp_pc;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 30'hC00 + 30'(i);
            imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h2408_0001;
            instr_ready = 1'b1; npc = exp_pc + 30'd1;
            tick();
            imem_bus.imem_ack = 1'b0;
            checks++; if (instr_valid !== 1'b1 || imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL zw_valid[%0d]: valid=%b req=%b want 1/0", i, instr_valid, imem_bus.imem_req); end
            checks++; if (instr !== 32'h2408_0001) begin errors++; $display("FAIL zw_instr[%0d]: got %h want 24080001", i, instr); end
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL zw_pc[%0d]: got %h want %h", i, pc, exp_pc); end
            tick();
            exp_fetch++;
            checks++; if (pc !== exp_pc + 30'd1 || imem_bus.imem_addr !== exp_pc + 30'd1) begin errors++; $display("FAIL zw_next[%0d]: pc=%h addr=%h want %h", i, pc, imem_bus.imem_addr, exp_pc + 30'd1); end
            checks++; if (instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL zw_req[%0d]: valid=%b req=%b want 0/1", i, instr_valid, imem_bus.imem_req); end
        end
        checks++; if (fetch_cnt !== (PERF_EN ? exp_fetch : 32'd0)) begin errors++; $display("FAIL zw_fetch_cnt: got %0d want %0d", fetch_cnt, PERF_EN ? exp_fetch : 32'd0); end
    endtask

    // Ack arrives in the 4th request cycle at 0xC03.
    task automatic test_delayed_ack();
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            imem_bus.imem_ack = 1'b0;
            tick();
            exp_stall++;
            checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 30'hC03 || instr_valid !== 1'b0) begin errors++; $display("FAIL dly_wait[%0d]: req=%b addr=%h valid=%b want 1/c03/0", k, imem_bus.imem_req, imem_bus.imem_addr, instr_valid); end
        end
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h8C09_0004;
        tick();
        imem_bus.imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h8C09_0004) begin errors++; $display("FAIL dly_valid: valid=%b instr=%h want 1/8c090004", instr_valid, instr); end
        checks++; if (stall_cnt !== (PERF_EN ? exp_stall : 32'd0)) begin errors++; $display("FAIL dly_stall_cnt: got %0d want %0d", stall_cnt, PERF_EN ? exp_stall : 32'd0); end
    endtask

    // Decode stalls 5 cycles in VALID; stray acks and junk npc are ignored.
    task automatic test_hold();
        npc = 30'h3FFF_FFFF; instr_ready = 1'b0; imem_bus.imem_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            imem_bus.imem_ack = (k % 2 == 0);
            tick();
            checks++; if (pc !== 30'hC03 || instr !== 32'h8C09_0004 || instr_valid !== 1'b1 || imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL hold[%0d]: pc=%h instr=%h valid=%b req=%b want c03/8c090004/1/0", k, pc, instr, instr_valid, imem_bus.imem_req); end
        end
        imem_bus.imem_ack = 1'b0; instr_ready = 1'b1; npc = 30'hC04;
        tick();
        exp_fetch++;
        instr_ready = 1'b0;
        checks++; if (pc !== 30'hC04 || imem_bus.imem_addr !== 30'hC04 || dbg_state !== ST_REQ) begin errors++; $display("FAIL hold_release: pc=%h addr=%h st=%0d want c04/c04/1", pc, imem_bus.imem_addr, dbg_state); end
        checks++; if (fetch_cnt !== (PERF_EN ? exp_fetch : 32'd0)) begin errors++; $display("FAIL hold_fetch_cnt: got %0d want %0d", fetch_cnt, PERF_EN ? exp_fetch : 32'd0); end
    endtask

    // Flush to 0x1000 while the response for 0xC04 is 2 cycles away.
    task automatic test_flush_drop();
        imem_bus.imem_ack = 1'b0;
        tick(); exp_stall++;
        flush = 1'b1; flush_pc = 30'h1000;
        tick(); exp_stall++;
        flush = 1'b0;
        checks++; if (dbg_state !== ST_DROP || pc !== 30'h1000) begin errors++; $display("FAIL drop_enter: st=%0d pc=%h want 3/1000", dbg_state, pc); end
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 30'hC04 || instr_valid !== 1'b0) begin errors++; $display("FAIL drop_addr: req=%b addr=%h valid=%b want 1/c04/0", imem_bus.imem_req, imem_bus.imem_addr, instr_valid); end
        tick(); exp_stall++;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_bus.imem_ack = 1'b0;
        checks++; if (dbg_state !== ST_REQ || imem_bus.imem_addr !== 30'h1000 || instr_valid !== 1'b0) begin errors++; $display("FAIL drop_redirect: st=%0d addr=%h valid=%b want 1/1000/0", dbg_state, imem_bus.imem_addr, instr_valid); end
        checks++; if (instr !== 32'h8C09_0004) begin errors++; $display("FAIL drop_discard: instr=%h want 8c090004", instr); end
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h2108_0002;
        tick();
        imem_bus.imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h2108_0002 || pc !== 30'h1000) begin errors++; $display("FAIL drop_fetch: valid=%b instr=%h pc=%h want 1/21080002/1000", instr_valid, instr, pc); end
        instr_ready = 1'b1; npc = 30'h1001;
        tick(); exp_fetch++;
        instr_ready = 1'b0;
        checks++; if (pc !== 30'h1001 || imem_bus.imem_addr !== 30'h1001) begin errors++; $display("FAIL drop_next: pc=%h addr=%h want 1001", pc, imem_bus.imem_addr); end
        checks++; if (stall_cnt !== (PERF_EN ? exp_stall : 32'd0)) begin errors++; $display("FAIL drop_stall_cnt: got %0d want %0d", stall_cnt, PERF_EN ? exp_stall : 32'd0); end
    endtask

    // Flush and ack in the same REQ cycle.
    task automatic test_flush_ack();
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hBAD0_BAD0;
        flush = 1'b1; flush_pc = 30'h2000;
        tick();
        flush = 1'b0; imem_bus.imem_ack = 1'b0;
        checks++; if (dbg_state !== ST_REQ || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 30'h2000 || pc !== 30'h2000) begin errors++; $display("FAIL fa_redirect: st=%0d req=%b addr=%h pc=%h want 1/1/2000/2000", dbg_state, imem_bus.imem_req, imem_bus.imem_addr, pc); end
        checks++; if (instr !== 32'h2108_0002 || instr_valid !== 1'b0) begin errors++; $display("FAIL fa_discard: instr=%h valid=%b want 21080002/0", instr, instr_valid); end
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h0000_0020;
        tick();
        imem_bus.imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0020) begin errors++; $display("FAIL fa_fetch: valid=%b instr=%h want 1/00000020", instr_valid, instr); end
    endtask

    // Flush and instr_ready together in VALID.
    task automatic test_flush_ready();
        instr_ready = 1'b1; npc = 30'h2001; flush = 1'b1; flush_pc = 30'h3000;
        tick();
        instr_ready = 1'b0; flush = 1'b0;
        checks++; if (pc !== 30'h3000 || imem_bus.imem_addr !== 30'h3000 || instr_valid !== 1'b0) begin errors++; $display("FAIL fr_pc: pc=%h addr=%h valid=%b want 3000/3000/0", pc, imem_bus.imem_addr, instr_valid); end
        checks++; if (fetch_cnt !== (PERF_EN ? exp_fetch : 32'd0)) begin errors++; $display("FAIL fr_fetch_cnt: got %0d want %0d", fetch_cnt, PERF_EN ? exp_fetch : 32'd0); end
    endtask

    // Two flushes in a row while draining, then reset from DROP.
    task automatic test_reset_in_drop();
        imem_bus.imem_ack = 1'b0; flush = 1'b1; flush_pc = 30'h3100;
        tick(); exp_stall++;
        flush_pc = 30'h3200;
        tick(); exp_stall++;
        flush = 1'b0;
        checks++; if (dbg_state !== ST_DROP || pc !== 30'h3200 || imem_bus.imem_addr !== 30'h3000) begin errors++; $display("FAIL dd_latest: st=%0d pc=%h addr=%h want 3/3200/3000", dbg_state, pc, imem_bus.imem_addr); end
        checks++; if (stall_cnt !== (PERF_EN ? exp_stall : 32'd0)) begin errors++; $display("FAIL dd_stall_cnt: got %0d want %0d", stall_cnt, PERF_EN ? exp_stall : 32'd0); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_fetch = 0; exp_stall = 0;
        checks++; if (pc !== 30'hC00 || imem_bus.imem_addr !== 30'hC00 || imem_bus.imem_req !== 1'b0 || instr !== 32'h0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_drop: pc=%h addr=%h req=%b instr=%h st=%0d want c00/c00/0/0/0", pc, imem_bus.imem_addr, imem_bus.imem_req, instr, dbg_state); end
        checks++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_drop_cnt: got %0d/%0d want 0/0", fetch_cnt, stall_cnt); end
        tick();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 30'hC00) begin errors++; $display("FAIL rst_drop_req: req=%b addr=%h want 1/c00", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_hold();
        test_flush_drop();
        test_flush_ack();
        test_flush_ready();
        test_reset_in_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
